// File: rtl/spi_to_axi_pkg.sv
// Shared defaults and helpers for the SPI-to-AXI4-Stream bridge.
package spi_to_axi_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 5;
    localparam int DEF_CNT_MAX    = 511;
    localparam int DEF_KEEP_WIDTH = 1;

    // Number of words the bridge can hold for a given log2 depth.
    function automatic int buf_depth(input int cnt_width);
        return 1 << cnt_width;
    endfunction

    localparam int BUF_DEPTH = buf_depth(DEF_CNT_WIDTH);

    // Beat counter width is derived from the packet length only.
    function automatic int beat_width(input int cnt_max);
        return (cnt_max < 1) ? 1 : $clog2(cnt_max + 1);
    endfunction

    // Where the output register takes its next value from.
    typedef enum logic [1:0] {
        SRC_HOLD   = 2'd0,
        SRC_FIFO   = 2'd1,
        SRC_BYPASS = 2'd2,
        SRC_IDLE   = 2'd3
    } out_src_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous FIFO with the head word visible on rd_data while not empty.
// Depth need not be a power of two; a write is accepted when full if a read
// happens in the same cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 31,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             wr_ok_s;
    logic             rd_ok_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign full    = (count_r == CNT_FULL);
    assign empty   = (count_r == {CNT_W{1'b0}});
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];

    // Qualify requests against the current fill level.
    always_comb begin
        wr_ok_s = wr_en & (~full | rd_en);
        rd_ok_s = rd_en & ~empty;
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (rd_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({wr_ok_s, rd_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/spi_to_axi.sv
// SPI word receive path to AXI4-Stream master. One word is captured per rising
// edge of i_DV, buffered, and streamed in fixed-length packets. The registered
// output stage counts as one of the 2**CNT_WIDTH storage slots, so the FIFO
// behind it holds one word fewer.
module spi_to_axi
    import spi_to_axi_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH,
    parameter int CNT_MAX    = DEF_CNT_MAX,
    parameter int KEEP_WIDTH = DEF_KEEP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_L,
    input  logic                  i_DV,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_fifo_en,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [31:0]           o_counter
);

    localparam int DEPTH      = buf_depth(CNT_WIDTH);
    localparam int FIFO_DEPTH = DEPTH - 1;
    localparam int FCNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int OCC_W      = CNT_WIDTH + 1;
    localparam int BEAT_W     = beat_width(CNT_MAX);

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(CNT_MAX);
    localparam logic [OCC_W-1:0]  EN_LIMIT  = OCC_W'(DEPTH - 1);

    logic                  dv_q_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] tdata_r;
    logic [KEEP_WIDTH-1:0] tkeep_r;
    logic                  tlast_r;
    logic                  fifo_en_r;
    logic [BEAT_W-1:0]     beat_r;

    logic                  capture_s;
    logic                  pop_s;
    logic                  load_s;
    out_src_e              src_s;
    logic                  fifo_wr_s;
    logic                  fifo_rd_s;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] fifo_rdata_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [FCNT_W-1:0]     fifo_count_s;
    logic [OCC_W-1:0]      occ_s;
    logic [OCC_W-1:0]      occ_next_s;
    logic                  valid_next_s;
    logic [DATA_WIDTH-1:0] data_next_s;
    logic [BEAT_W-1:0]     beat_next_s;

    sync_fifo_fwft #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_L),
        .wr_en   (fifo_wr_s),
        .wr_data (i_data),
        .rd_en   (fifo_rd_s),
        .rd_data (fifo_rdata_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    // Steer captures and pick the next output word, keeping arrival order.
    always_comb begin
        capture_s    = i_DV & ~dv_q_r;
        pop_s        = out_valid_r & m_axis_tready;
        load_s       = ~out_valid_r | pop_s;
        fifo_rd_s    = 1'b0;
        valid_next_s = 1'b0;
        data_next_s  = tdata_r;

        if (!load_s) begin
            src_s = SRC_HOLD;
        end else if (!fifo_empty_s) begin
            src_s = SRC_FIFO;
        end else if (capture_s) begin
            src_s = SRC_BYPASS;
        end else begin
            src_s = SRC_IDLE;
        end

        case (src_s)
            SRC_HOLD: begin
                valid_next_s = 1'b1;
                data_next_s  = tdata_r;
            end
            SRC_FIFO: begin
                valid_next_s = 1'b1;
                data_next_s  = fifo_rdata_s;
                fifo_rd_s    = 1'b1;
            end
            SRC_BYPASS: begin
                valid_next_s = 1'b1;
                data_next_s  = i_data;
            end
            SRC_IDLE: begin
                valid_next_s = 1'b0;
                data_next_s  = tdata_r;
            end
            default: begin
                valid_next_s = 1'b0;
                data_next_s  = tdata_r;
            end
        endcase

        // A capture that neither bypasses nor finds room is dropped.
        fifo_wr_s = capture_s & (src_s != SRC_BYPASS) & (~fifo_full_s | fifo_rd_s);
        accept_s  = capture_s & ((src_s == SRC_BYPASS) | fifo_wr_s);

        occ_s      = OCC_W'(fifo_count_s) + OCC_W'(out_valid_r);
        occ_next_s = occ_s + OCC_W'(accept_s) - OCC_W'(pop_s);

        if (pop_s) begin
            beat_next_s = (beat_r == BEAT_LAST) ? {BEAT_W{1'b0}} : beat_r + BEAT_W'(1);
        end else begin
            beat_next_s = beat_r;
        end
    end

    // Edge detector, output register, packet counter and upstream request.
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            dv_q_r      <= 1'b1;
            out_valid_r <= 1'b0;
            tdata_r     <= {DATA_WIDTH{1'b0}};
            tkeep_r     <= {KEEP_WIDTH{1'b0}};
            tlast_r     <= 1'b0;
            fifo_en_r   <= 1'b0;
            beat_r      <= {BEAT_W{1'b0}};
        end else begin
            dv_q_r      <= i_DV;
            out_valid_r <= valid_next_s;
            tdata_r     <= data_next_s;
            tkeep_r     <= valid_next_s ? {KEEP_WIDTH{1'b1}} : {KEEP_WIDTH{1'b0}};
            tlast_r     <= valid_next_s & (beat_next_s == BEAT_LAST);
            fifo_en_r   <= (occ_next_s < EN_LIMIT);
            beat_r      <= beat_next_s;
        end
    end

    assign m_axis_tvalid = out_valid_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tkeep  = tkeep_r;
    assign m_axis_tlast  = tlast_r;
    assign o_fifo_en     = fifo_en_r;
    assign o_counter     = 32'(beat_r);

endmodule

// File: tb/tb_spi_to_axi.sv
// Self-checking bench for spi_to_axi using a queue-based reference model.
module tb_spi_to_axi;

    logic        clk = 1'b0;
    logic        rst_L;
    logic        i_DV;
    logic [31:0] i_data;
    logic        o_fifo_en;
    logic        m_axis_tready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic [0:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic [31:0] o_counter;

    int checks = 0;
    int errors = 0;

    // Reference model: words held by the bridge, oldest first.
    logic [31:0] q[$];
    int          beat;
    bit          prev_dv;
    bit          en_exp;

    spi_to_axi dut (
        .clk           (clk),
        .rst_L         (rst_L),
        .i_DV          (i_DV),
        .i_data        (i_data),
        .o_fifo_en     (o_fifo_en),
        .m_axis_tready (m_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .o_counter     (o_counter)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model across the edge, and
    // return at the following falling edge.
    task automatic tick(input bit dv, input logic [31:0] d, input bit rdy);
        bit hs;
        bit cap;
        i_DV          = dv;
        i_data        = d;
        m_axis_tready = rdy;
        hs  = (q.size() != 0) && rdy;
        cap = dv && !prev_dv;
        prev_dv = dv;
        if (hs) begin
            void'(q.pop_front());
            beat = (beat == 511) ? 0 : beat + 1;
        end
        if (cap && q.size() < 32) q.push_back(d);
        en_exp = (q.size() < 31);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input bit dv);
        rst_L         = 1'b0;
        i_DV          = dv;
        m_axis_tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        q.delete();
        beat    = 0;
        prev_dv = 1'b1;
        en_exp  = 1'b0;
        rst_L   = 1'b1;
    endtask

    task automatic test_reset;
        i_data = 32'hDEAD_BEEF;
        do_reset(1'b1);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== 1'b0) begin errors++; $display("FAIL reset_tkeep got %b want 0", m_axis_tkeep); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
        checks++; if (o_fifo_en !== 1'b0) begin errors++; $display("FAIL reset_fifo_en got %b want 0", o_fifo_en); end
        checks++; if (o_counter !== 32'd0) begin errors++; $display("FAIL reset_counter got %0d want 0", o_counter); end
        // i_DV still high from reset must not count as an edge.
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, $urandom, 1'b1);
            checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_dv_held got tvalid %0b want 0", m_axis_tvalid); end
        end
        checks++; if (o_fifo_en !== 1'b1) begin errors++; $display("FAIL reset_fifo_en_release got %b want 1", o_fifo_en); end
        tick(1'b0, $urandom, 1'b1);
        tick(1'b0, $urandom, 1'b1);
    endtask

    task automatic test_single;
        tick(1'b1, 32'h444, 1'b1);
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid got %0b want 1", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 32'h444) begin errors++; $display("FAIL single_tdata got %h want 444", m_axis_tdata); end
        checks++; if (m_axis_tkeep !== 1'b1) begin errors++; $display("FAIL single_tkeep got %b want 1", m_axis_tkeep); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL single_tlast got %b want 0", m_axis_tlast); end
        checks++; if (o_counter !== 32'd0) begin errors++; $display("FAIL single_counter0 got %0d want 0", o_counter); end
        tick(1'b0, $urandom, 1'b1);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_drained got tvalid %0b want 0", m_axis_tvalid); end
        checks++; if (o_counter !== 32'd1) begin errors++; $display("FAIL single_counter1 got %0d want 1", o_counter); end
    endtask

    task automatic test_strobe_period;
        int k = 0;
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 12; c++) begin
                if (m_axis_tvalid === 1'b1) begin
                    checks++; if (m_axis_tdata !== 32'h333 + k) begin errors++; $display("FAIL period_data got %h want %h", m_axis_tdata, 32'h333 + k); end
                    k++;
                end
                tick(c < 8, (c == 0) ? 32'h333 + p : $urandom, 1'b1);
            end
        end
        checks++; if (k != 6) begin errors++; $display("FAIL period_count got %0d beats want 6", k); end
    endtask

    task automatic test_backpressure;
        logic [31:0] w [3];
        for (int i = 0; i < 3; i++) w[i] = $urandom;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, w[i], 1'b0);
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== w[0]) begin errors++; $display("FAIL bp_hold got v=%0b d=%h want v=1 d=%h", m_axis_tvalid, m_axis_tdata, w[0]); end
            tick(1'b0, $urandom, 1'b0);
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== w[0]) begin errors++; $display("FAIL bp_hold got v=%0b d=%h want v=1 d=%h", m_axis_tvalid, m_axis_tdata, w[0]); end
        end
        for (int i = 0; i < 3; i++) begin
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== w[i]) begin errors++; $display("FAIL bp_drain%0d got v=%0b d=%h want v=1 d=%h", i, m_axis_tvalid, m_axis_tdata, w[i]); end
            tick(1'b0, $urandom, 1'b1);
        end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL bp_empty got tvalid %0b want 0", m_axis_tvalid); end
    endtask

    task automatic test_overflow;
        logic [31:0] w [33];
        for (int i = 0; i < 33; i++) w[i] = $urandom;
        for (int i = 0; i < 33; i++) begin
            tick(1'b1, w[i], 1'b0);
            checks++; if (o_fifo_en !== (i + 1 < 31)) begin errors++; $display("FAIL ovf_fifo_en word%0d got %b want %b", i + 1, o_fifo_en, (i + 1 < 31)); end
            tick(1'b0, $urandom, 1'b0);
        end
        for (int i = 0; i < 32; i++) begin
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== w[i]) begin errors++; $display("FAIL ovf_drain%0d got v=%0b d=%h want v=1 d=%h", i, m_axis_tvalid, m_axis_tdata, w[i]); end
            checks++; if (o_fifo_en !== en_exp) begin errors++; $display("FAIL ovf_drain_en got %b want %b", o_fifo_en, en_exp); end
            tick(1'b0, $urandom, 1'b1);
        end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ovf_extra got tvalid %0b want 0", m_axis_tvalid); end
        checks++; if (o_fifo_en !== 1'b1) begin errors++; $display("FAIL ovf_en_after got %b want 1", o_fifo_en); end
    endtask

    // Stream n beats with tready high, checking index and tlast per beat.
    task automatic run_stream(input int n, output int tlast_hits);
        int h   = 0;
        int cyc = 0;
        tlast_hits = 0;
        while (h < n && cyc < 4 * n + 20) begin
            if (m_axis_tvalid === 1'b1) begin
                checks++; if (m_axis_tlast !== (h % 512 == 511)) begin errors++; $display("FAIL pkt_tlast beat%0d got %b want %b", h + 1, m_axis_tlast, (h % 512 == 511)); end
                checks++; if (o_counter !== 32'(h % 512)) begin errors++; $display("FAIL pkt_counter beat%0d got %0d want %0d", h + 1, o_counter, h % 512); end
                if (m_axis_tlast === 1'b1) tlast_hits++;
                h++;
            end
            tick((cyc % 2) == 0, $urandom, 1'b1);
            cyc++;
        end
        checks++; if (h != n) begin errors++; $display("FAIL pkt_timeout got %0d beats want %0d", h, n); end
    endtask

    task automatic test_packets;
        int hits;
        do_reset(1'b0);
        run_stream(1030, hits);
        checks++; if (hits != 2) begin errors++; $display("FAIL pkt_tlast_count got %0d want 2", hits); end
        do_reset(1'b0);
        run_stream(700, hits);
        checks++; if (hits != 1) begin errors++; $display("FAIL pkt700_tlast_count got %0d want 1", hits); end
        tick(1'b1, $urandom, 1'b0);
        do_reset(1'b1);
        checks++; if (m_axis_tvalid !== 1'b0 || o_counter !== 32'd0) begin errors++; $display("FAIL midreset got v=%0b cnt=%0d want v=0 cnt=0", m_axis_tvalid, o_counter); end
        tick(1'b0, $urandom, 1'b1);
        run_stream(515, hits);
        checks++; if (hits != 1) begin errors++; $display("FAIL pkt_after_reset_tlast got %0d want 1", hits); end
    endtask

    task automatic test_random;
        bit rdy;
        for (int i = 0; i < 1500; i++) begin
            checks++; if (m_axis_tvalid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_tvalid cyc%0d got %b want %b", i, m_axis_tvalid, (q.size() != 0)); end
            if (q.size() != 0) begin
                checks++; if (m_axis_tdata !== q[0]) begin errors++; $display("FAIL rnd_tdata cyc%0d got %h want %h", i, m_axis_tdata, q[0]); end
            end
            checks++; if (m_axis_tlast !== (q.size() != 0 && beat == 511)) begin errors++; $display("FAIL rnd_tlast cyc%0d got %b", i, m_axis_tlast); end
            checks++; if (m_axis_tkeep !== ((q.size() != 0) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL rnd_tkeep cyc%0d got %b", i, m_axis_tkeep); end
            checks++; if (o_counter !== 32'(beat)) begin errors++; $display("FAIL rnd_counter cyc%0d got %0d want %0d", i, o_counter, beat); end
            checks++; if (o_fifo_en !== en_exp) begin errors++; $display("FAIL rnd_fifo_en cyc%0d got %b want %b", i, o_fifo_en, en_exp); end
            // Alternate phases that fill the buffer and phases that drain it.
            if (((i / 150) % 2) == 0) rdy = ($urandom_range(0, 7) == 0);
            else                      rdy = ($urandom_range(0, 3) != 0);
            tick($urandom_range(0, 1) == 1, $urandom, rdy);
        end
    endtask

    initial begin
        rst_L         = 1'b0;
        i_DV          = 1'b0;
        i_data        = 32'h0;
        m_axis_tready = 1'b0;
        beat          = 0;
        prev_dv       = 1'b1;
        en_exp        = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_strobe_period();
        test_backpressure();
        test_overflow();
        test_packets();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
